// File: rtl/ir_alarm_controller.sv
// ir_alarm_controller: IR sensor alarm sequencer.
// Synchronizes and debounces IR_IN. A qualified detection while armed plays
// a bounded beep pattern on BUZZER, then waits out a hold-off before re-arming.
// Optional macro IR_ALARM_LATCH_EN: when defined, the beep pattern repeats
// until ACK, ARM=0 or RST instead of ending after BEEP_COUNT beeps.
module ir_alarm_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BEEP_ON_CYCLES  = 3,
  parameter int BEEP_OFF_CYCLES = 2,
  parameter int BEEP_COUNT      = 3,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IR_IN,
  input  logic       ARM,
  input  logic       ACK,
  output logic       BUZZER,
  output logic [1:0] STATE,
  output logic [7:0] EVENT_CNT
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'b00,
    ST_ARMED    = 2'b01,
    ST_ALERT    = 2'b10,
    ST_HOLDOFF  = 2'b11
  } state_t;

  localparam int PH_MAX = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int BC_W   = $clog2(BEEP_COUNT + 1);
  localparam int HO_W   = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PH_W-1:0] ON_LAST  = PH_W'(BEEP_ON_CYCLES - 1);
  localparam logic [PH_W-1:0] OFF_LAST = PH_W'(BEEP_OFF_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BEEP_COUNT - 1);
  localparam logic [HO_W-1:0] HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);

  logic [1:0]      sync_reg;
  logic            ir_s;
  state_t          state_reg, state_next;
  logic            buzzer_reg, buzzer_next;
  logic            phase_on_reg, phase_on_next;
  logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
  logic [PH_W-1:0] ph_cnt_reg, ph_cnt_next;
  logic [BC_W-1:0] beep_cnt_reg, beep_cnt_next;
  logic [HO_W-1:0] ho_cnt_reg, ho_cnt_next;
  logic [7:0]      evt_reg, evt_next;
  logic            detect;

  assign ir_s      = sync_reg[1];
  assign BUZZER    = buzzer_reg;
  assign STATE     = state_reg;
  assign EVENT_CNT = evt_reg;

  // Two-flop synchronizer for the asynchronous sensor input.
  always_ff @(posedge CLK) begin
    if (RST) sync_reg <= 2'b00;
    else     sync_reg <= {sync_reg[0], IR_IN};
  end

  // State and counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_DISARMED;
      buzzer_reg   <= 1'b0;
      phase_on_reg <= 1'b0;
      db_cnt_reg   <= '0;
      ph_cnt_reg   <= '0;
      beep_cnt_reg <= '0;
      ho_cnt_reg   <= '0;
      evt_reg      <= 8'd0;
    end else begin
      state_reg    <= state_next;
      buzzer_reg   <= buzzer_next;
      phase_on_reg <= phase_on_next;
      db_cnt_reg   <= db_cnt_next;
      ph_cnt_reg   <= ph_cnt_next;
      beep_cnt_reg <= beep_cnt_next;
      ho_cnt_reg   <= ho_cnt_next;
      evt_reg      <= evt_next;
    end
  end

  // A detection needs DEBOUNCE_CYCLES consecutive synchronized-high cycles in ARMED.
  assign detect = (state_reg == ST_ARMED) && ir_s && (db_cnt_reg == DB_LAST);

  // Next-state, beep sequencing and counter updates; ARM=0 overrides everything.
  always_comb begin
    state_next    = state_reg;
    buzzer_next   = buzzer_reg;
    phase_on_next = phase_on_reg;
    ph_cnt_next   = ph_cnt_reg;
    beep_cnt_next = beep_cnt_reg;
    ho_cnt_next   = ho_cnt_reg;
    evt_next      = evt_reg;
    db_cnt_next   = (ir_s && state_reg == ST_ARMED) ? db_cnt_reg + 1'b1 : '0;

    if (!ARM) begin
      state_next    = ST_DISARMED;
      buzzer_next   = 1'b0;
      phase_on_next = 1'b0;
      db_cnt_next   = '0;
      ph_cnt_next   = '0;
      beep_cnt_next = '0;
      ho_cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_DISARMED: state_next = ST_ARMED;
        ST_ARMED: begin
          if (detect) begin
            state_next    = ST_ALERT;
            buzzer_next   = 1'b1;
            phase_on_next = 1'b1;
            ph_cnt_next   = '0;
            beep_cnt_next = '0;
            if (evt_reg != 8'hFF) evt_next = evt_reg + 8'd1;
          end
        end
        ST_ALERT: begin
          if (ACK) begin
            state_next  = ST_HOLDOFF;
            buzzer_next = 1'b0;
            ho_cnt_next = '0;
          end else if (phase_on_reg) begin
            if (ph_cnt_reg == ON_LAST) begin
              phase_on_next = 1'b0;
              buzzer_next   = 1'b0;
              ph_cnt_next   = '0;
            end else begin
              ph_cnt_next = ph_cnt_reg + 1'b1;
            end
          end else if (ph_cnt_reg == OFF_LAST) begin
            ph_cnt_next = '0;
            if (beep_cnt_reg == BC_LAST) begin
`ifdef IR_ALARM_LATCH_EN
              beep_cnt_next = '0;
              phase_on_next = 1'b1;
              buzzer_next   = 1'b1;
`else
              beep_cnt_next = '0;
              state_next    = ST_HOLDOFF;
              buzzer_next   = 1'b0;
              ho_cnt_next   = '0;
`endif
            end else begin
              beep_cnt_next = beep_cnt_reg + 1'b1;
              phase_on_next = 1'b1;
              buzzer_next   = 1'b1;
            end
          end else begin
            ph_cnt_next = ph_cnt_reg + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (ho_cnt_reg == HO_LAST) begin
            state_next  = ST_ARMED;
            ho_cnt_next = '0;
          end else begin
            ho_cnt_next = ho_cnt_reg + 1'b1;
          end
        end
        default: state_next = ST_DISARMED;
      endcase
    end
  end

endmodule

// File: doc/ir_alarm_controller.md
# ir_alarm_controller

Sequencing controller for the IR-sensor buzzer path. It synchronizes and debounces the raw IR sensor input and arms or disarms detection. On a qualified detection it plays a bounded on/off beep pattern on the buzzer, then enforces a hold-off before re-arming. It sits between the IR sensor pin, a user arm/acknowledge control, and the physical buzzer driver.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive synchronized-high cycles needed to qualify a detection; must be ≥1.
- BEEP_ON_CYCLES, default 3: BUZZER high time per beep, in cycles; must be ≥1.
- BEEP_OFF_CYCLES, default 2: BUZZER low time per beep, in cycles; must be ≥1.
- BEEP_COUNT, default 3: number of beeps per alert; must be ≥1.
- HOLDOFF_CYCLES, default 8: cycles spent in HOLDOFF before returning to ARMED; must be ≥1.

Ports (clock and reset first):
- CLK, input, 1: system clock. All logic is clocked on the rising edge.
- RST, input, 1: reset. One clock; reset is synchronous and active-high.
- IR_IN, input, 1: raw IR sensor (1 = object present). Asynchronous to CLK.
- ARM, input, 1: level-sensitive. 1 = detection enabled, 0 = disarmed.
- ACK, input, 1: single-cycle acknowledge. Ends an alert early.
- BUZZER, output, 1: registered buzzer drive.
- STATE, output, 2: current state. 00 DISARMED, 01 ARMED, 10 ALERT, 11 HOLDOFF.
- EVENT_CNT, output, 8: number of alerts entered since reset. Saturates at 255.

## Operation
- **Input synchronizer:** IR_IN passes through a 2-flop synchronizer; ir_s is the second stage.
- **Debounce counter:** width $clog2(DEBOUNCE_CYCLES+1). Clears whenever ir_s=0 or STATE≠ARMED. Otherwise it increments.
- **Detection:** qualified when ir_s=1 and the count equals DEBOUNCE_CYCLES-1 while in ARMED.
- **State transitions:**
  - DISARMED → ARMED when ARM=1.
  - ARMED → ALERT on qualified detection. On the same edge: BUZZER←1, beep phase = ON, phase counter cleared, beep counter cleared, EVENT_CNT increments (saturating).
- **ALERT beep sequencing:**
  - Phase counter counts BEEP_ON_CYCLES cycles in ON and BEEP_OFF_CYCLES cycles in OFF. BUZZER=1 only in the ON phase.
  - Completing an OFF phase increments the beep counter. When the completed beep is number BEEP_COUNT, go to HOLDOFF; otherwise start the next ON phase.
  - ACK=1 in ALERT → HOLDOFF with BUZZER←0 on that edge. ACK outside ALERT is ignored.
- **HOLDOFF:**
  - Counts HOLDOFF_CYCLES cycles, then → ARMED. IR is ignored here.
  - Debounce restarts from 0 on re-entry to ARMED. An IR_IN still held high re-triggers after DEBOUNCE_CYCLES more cycles.
- **Priority, highest first:** RST, ARM=0, ACK, beep/holdoff completion, detection.
  - ARM=0 in any state → DISARMED on the next edge, with BUZZER←0 and all counters cleared. EVENT_CNT is retained.
- **Reset values:** STATE=DISARMED, BUZZER=0, EVENT_CNT=0, synchronizer flops=0, all counters=0.
  - RST mid-alert silences BUZZER on that edge.

## Timing
- Edge numbering: edge 0 is the first edge at which IR_IN=1 is sampled, in ARMED, with IR_IN held high afterwards.
  - ir_s=1 is visible from after edge 1.
  - BUZZER=1 and STATE=10 are visible after edge DEBOUNCE_CYCLES+1. With defaults, that is after edge 5.
- Full-length alert: BEEP_COUNT×(BEEP_ON_CYCLES+BEEP_OFF_CYCLES) cycles in ALERT, then exactly HOLDOFF_CYCLES cycles in HOLDOFF. With defaults: 15 cycles, then 8.
- An IR pulse shorter than DEBOUNCE_CYCLES synchronized cycles never triggers. A single low cycle restarts the debounce.
- ACK has 1-cycle latency: STATE=11 and BUZZER=0 are visible after the edge that samples ACK=1.
- ARM is sampled directly, with no synchronizer. The driver is responsible for keeping ARM synchronous to CLK.

## Configuration
- Macro IR_ALARM_LATCH_EN.
- **Defined:** the alert latches. The beep pattern repeats indefinitely, with the beep counter wrapping and no transition to HOLDOFF on count. The alert leaves ALERT only on ACK, ARM=0 or RST.
- **Undefined:** the alert self-terminates after BEEP_COUNT beeps, as described in Operation.

## Test plan
- Reset, then ARM=1; IR_IN high for 3 cycles, then low → BUZZER stays 0, STATE=01, EVENT_CNT=0.
- ARM=1; IR_IN held high from edge 0, default parameters → BUZZER rises after edge 5 and shows pattern 1,1,1,0,0 three times. STATE=11 for 8 cycles, then 01. EVENT_CNT=1.
- ACK pulse on the 2nd cycle of the alert → BUZZER=0 and STATE=11 on the next edge. Return to 01 after 8 cycles.
- ARM dropped mid-alert, in the same cycle as ACK → STATE=00 and BUZZER=0 next edge. EVENT_CNT retained.
- IR_IN held high through HOLDOFF → re-alert 4 cycles after re-entering ARMED. EVENT_CNT=2. Force 256 alerts → EVENT_CNT saturates at 255.
- With IR_ALARM_LATCH_EN defined: alert runs ≥10 beeps with no HOLDOFF; ACK → HOLDOFF. RST asserted mid-alert → all outputs at reset values after that edge.
